// File: rtl/dsp_core.sv
// dsp_core: single SIMD lane processor with bus-loaded instruction memory and handshaked data port
module dsp_core #(
    parameter int REG_SIZE     = 8,
    parameter int ADDR_SIZE    = 8,
    parameter int INSN_SIZE    = 16,
    parameter int INSN_PER_BUS = 4,
    parameter int LOAD_CYCLES  = 4,
    parameter int NUM_REGS     = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              init_R0_flag,
    input  logic [REG_SIZE-1:0]               init_R0_data,
    input  logic [INSN_SIZE*INSN_PER_BUS-1:0] insn_data,
    input  logic [$clog2(LOAD_CYCLES)-1:0]    insn_load_counter,
    input  logic                              Start,
    output logic                              Ready,
    input  logic [REG_SIZE-1:0]               rd_data_M,
    input  logic                              ready_M,
    output logic [REG_SIZE-1:0]               wr_data_M,
    output logic [ADDR_SIZE-1:0]              addr_M,
    output logic [1:0]                        enable_M
);
    localparam int DEPTH = INSN_PER_BUS * LOAD_CYCLES;
    localparam int PC_W  = $clog2(DEPTH);
    localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_MUL = 4'h3, OP_CMPGE = 4'h4,
                           OP_BRF = 4'h5, OP_SET = 4'h6, OP_LD = 4'h7, OP_ST = 4'h8, OP_HALT = 4'hF;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, MEM} state_t;
    state_t               state;
    logic [INSN_SIZE-1:0] imem [DEPTH];
    logic [REG_SIZE-1:0]  regs [NUM_REGS];
    logic [PC_W-1:0]      pc;
    logic                 flag;
    logic [INSN_SIZE-1:0] insn;
    logic [3:0]           op, dst, s0, s1;
    logic [7:0]           imm;
    logic [REG_SIZE-1:0]  a, b, res;
    logic                 wr_en, last;
    always_comb begin
        insn  = imem[pc];
        op    = insn[15:12];
        dst   = insn[11:8];
        s0    = insn[7:4];
        s1    = insn[3:0];
        imm   = insn[7:0];
        a     = regs[s0];
        b     = regs[s1];
        res   = op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_MUL ? a * b : REG_SIZE'(imm);
        wr_en = op inside {OP_ADD, OP_SUB, OP_MUL, OP_SET};
        last  = pc == PC_W'(DEPTH - 1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            Ready     <= 1'b1;
            enable_M  <= '0;
            addr_M    <= '0;
            wr_data_M <= '0;
            pc        <= '0;
            flag      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            for (int i = 0; i < DEPTH; i++) imem[i] <= '0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (init_R0_flag) regs[0] <= init_R0_data;
                    if (Start) begin
                        for (int k = 0; k < INSN_PER_BUS; k++)
                            imem[PC_W'(INSN_PER_BUS * int'(insn_load_counter) + k)] <= insn_data[k*INSN_SIZE +: INSN_SIZE];
                        Ready <= 1'b0;
                        pc    <= '0;
                        state <= int'(insn_load_counter) == LOAD_CYCLES - 1 ? RUN : LOAD;
                    end
                end
                RUN: begin
                    if (op == OP_HALT) begin
                        state <= IDLE;
                        Ready <= 1'b1;
                    end else if (op == OP_LD || op == OP_ST) begin
                        state    <= MEM;
                        addr_M   <= ADDR_SIZE'(a);
                        enable_M <= op == OP_LD ? 2'b01 : 2'b10;
                        if (op == OP_ST) wr_data_M <= b;
                    end else begin
                        if (wr_en) regs[dst] <= res;
                        if (op == OP_CMPGE) flag <= a >= b;
                        if (op == OP_BRF && flag) pc <= imm[PC_W-1:0];
                        else begin
                            pc <= pc + 1'b1;
                            // falling off the last slot ends the program
                            if (last) begin
                                state <= IDLE;
                                Ready <= 1'b1;
                            end
                        end
                    end
                end
                MEM: begin
                    if (ready_M) begin
                        if (enable_M[0]) regs[dst] <= rd_data_M;
                        enable_M <= '0;
                        pc       <= pc + 1'b1;
                        state    <= last ? IDLE : RUN;
                        Ready    <= last;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsp_core.sv
// tb_dsp_core: directed and randomized program checks against an instruction-level reference model
module tb_dsp_core;
    logic        clk = 1'b0;
    logic        reset, init_R0_flag, Start, ready_M, Ready;
    logic [7:0]  init_R0_data, rd_data_M, wr_data_M, addr_M;
    logic [63:0] insn_data;
    logic [1:0]  insn_load_counter, enable_M;
    int          checks = 0, errors = 0;
    logic [15:0] prog [16];
    logic [7:0]  tb_mem [256];
    logic [7:0]  m_mem [256];
    logic [7:0]  m_regs [16];
    bit          m_flag;
    logic [17:0] exp_q[$], got_q[$];
    int          exp_cyc, cyc;

    always #5 clk = ~clk;

    dsp_core dut (
        .clk(clk), .reset(reset), .init_R0_flag(init_R0_flag), .init_R0_data(init_R0_data),
        .insn_data(insn_data), .insn_load_counter(insn_load_counter), .Start(Start), .Ready(Ready),
        .rd_data_M(rd_data_M), .ready_M(ready_M), .wr_data_M(wr_data_M), .addr_M(addr_M),
        .enable_M(enable_M)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
    endtask

    // Interprets prog: logs each memory request as {enable, addr, store data} and counts cycles at zero wait.
    task automatic model_run();
        int pc = 0, steps = 0;
        bit done = 0;
        logic [15:0] i;
        logic [3:0] op, d, a, b;
        logic [7:0] imm;
        exp_q.delete();
        exp_cyc = 0;
        while (!done && steps < 100) begin
            i = prog[pc]; op = i[15:12]; d = i[11:8]; a = i[7:4]; b = i[3:0]; imm = i[7:0];
            steps++;
            exp_cyc++;
            if (op == 4'hF) done = 1;
            else if (op == 4'h5 && m_flag) pc = int'(imm) % 16;
            else begin
                case (op)
                    4'h1: m_regs[d] = 8'((int'(m_regs[a]) + int'(m_regs[b])) % 256);
                    4'h2: m_regs[d] = 8'((int'(m_regs[a]) - int'(m_regs[b]) + 256) % 256);
                    4'h3: m_regs[d] = 8'((int'(m_regs[a]) * int'(m_regs[b])) % 256);
                    4'h4: m_flag = m_regs[a] >= m_regs[b];
                    4'h6: m_regs[d] = imm;
                    4'h7: begin
                        exp_q.push_back({2'b01, m_regs[a], 8'h00});
                        m_regs[d] = m_mem[m_regs[a]];
                        exp_cyc++;
                    end
                    4'h8: begin
                        exp_q.push_back({2'b10, m_regs[a], m_regs[b]});
                        m_mem[m_regs[a]] = m_regs[b];
                        exp_cyc++;
                    end
                    default: ;
                endcase
                if (pc == 15) done = 1;
                else pc++;
            end
        end
    endtask

    task automatic load_prog(input bit init, input logic [7:0] r0);
        chk("ready_idle", Ready, 1);
        for (int g = 0; g < 4; g++) begin
            init_R0_flag = init;
            init_R0_data = r0;
            if (g > 0 && $urandom_range(0, 2) == 0) begin
                Start = 0;
                insn_data = {$urandom, $urandom};
                insn_load_counter = 2'($urandom);
                @(posedge clk); #1;
                chk("ready_pause", Ready, 0);
            end
            Start = 1;
            insn_load_counter = 2'(g);
            insn_data = {prog[4*g+3], prog[4*g+2], prog[4*g+1], prog[4*g]};
            @(posedge clk); #1;
            chk("ready_load", Ready, 0);
        end
        Start = 0;
        init_R0_flag = 0;
        if (init) m_regs[0] = r0;
    endtask

    // nwait < 0 picks a random 0..3 wait per request
    task automatic run_prog(input int nwait);
        int w = 0, waits = 0;
        bit busy = 0;
        logic [17:0] cur = '0, now;
        got_q.delete();
        model_run();
        cyc = 0;
        while (cyc < 3000) begin
            Start = 1'($urandom);
            insn_data = {$urandom, $urandom};
            init_R0_flag = 1'($urandom);
            init_R0_data = 8'($urandom);
            insn_load_counter = 2'($urandom);
            @(posedge clk); #1;
            cyc++;
            if (Ready) break;
            if (enable_M != 2'b00) begin
                now = {enable_M, addr_M, enable_M == 2'b10 ? wr_data_M : 8'h00};
                if (!busy) begin
                    busy = 1;
                    w = nwait < 0 ? $urandom_range(0, 3) : nwait;
                    waits += w;
                    cur = now;
                    got_q.push_back(now);
                end else chk("mem_hold", now, cur);
                if (w == 0) begin
                    ready_M = 1;
                    rd_data_M = tb_mem[addr_M];
                    if (enable_M == 2'b10) tb_mem[addr_M] = wr_data_M;
                    busy = 0;
                end else begin
                    w--;
                    ready_M = 0;
                    rd_data_M = 8'($urandom);
                end
            end else begin
                ready_M = 1'($urandom);
                rd_data_M = 8'($urandom);
            end
        end
        Start = 0;
        init_R0_flag = 0;
        ready_M = 0;
        chk("done", Ready, 1);
        chk("cycles", cyc, exp_cyc + waits);
        chk("nreq", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("req", got_q[i], exp_q[i]);
    endtask

    initial begin
        reset = 1; Start = 0; init_R0_flag = 0; init_R0_data = 0; insn_data = 0;
        insn_load_counter = 0; ready_M = 0; rd_data_M = 0;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = 8'($urandom);
            m_mem[i] = tb_mem[i];
        end
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_flag = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        chk("rst_ready", Ready, 1);
        chk("rst_en", enable_M, 0);
        chk("rst_addr", addr_M, 0);
        chk("rst_wdata", wr_data_M, 0);
        @(posedge clk); #1;
        chk("idle_ready", Ready, 1);

        clear_prog();
        load_prog(0, 8'h00);
        run_prog(0);
        chk("nop_cycles", cyc, 16);
        chk("nop_noreq", got_q.size(), 0);

        clear_prog();
        prog[0] = 16'h6107; prog[1] = 16'h1201; prog[2] = 16'h8012; prog[3] = 16'hF000;
        load_prog(1, 8'd5);
        run_prog(3);
        chk("st_req", got_q[0], {2'b10, 8'd7, 8'd12});

        clear_prog();
        prog[0] = 16'h6303; prog[1] = 16'h7430; prog[2] = 16'h8034; prog[3] = 16'hF000;
        tb_mem[3] = 8'hA5;
        m_mem[3] = 8'hA5;
        load_prog(0, 8'h00);
        run_prog(1);
        chk("ld_req", got_q[0], {2'b01, 8'd3, 8'h00});
        chk("ld_val", got_q[1], {2'b10, 8'd3, 8'hA5});

        clear_prog();
        prog[0] = 16'h6509; prog[1] = 16'h6604; prog[2] = 16'h6702; prog[3] = 16'h4056;
        prog[4] = 16'h5006; prog[5] = 16'h8055; prog[6] = 16'h4076; prog[7] = 16'h5000;
        prog[8] = 16'h8067; prog[9] = 16'hF000;
        load_prog(0, 8'h00);
        run_prog(0);
        chk("brf_nreq", got_q.size(), 1);
        chk("brf_req", got_q[0], {2'b10, 8'd4, 8'd2});

        clear_prog();
        prog[0] = 16'h68C8; prog[1] = 16'h6964; prog[2] = 16'h1A89; prog[3] = 16'h6B10;
        prog[4] = 16'h6C11; prog[5] = 16'h3DBC; prog[6] = 16'h6E03; prog[7] = 16'h6F05;
        prog[8] = 16'h21EF; prog[9] = 16'h80EA; prog[10] = 16'h80FD; prog[11] = 16'h80B1;
        prog[12] = 16'hF000;
        load_prog(0, 8'h00);
        run_prog(-1);
        chk("add_wrap", got_q[0], {2'b10, 8'd3, 8'd44});
        chk("mul_low", got_q[1], {2'b10, 8'd5, 8'd16});
        chk("sub_wrap", got_q[2], {2'b10, 8'd16, 8'd254});

        clear_prog();
        prog[0] = 16'h8000;
        load_prog(0, 8'h00);
        Start = 0;
        ready_M = 0;
        for (int i = 0; i < 10 && enable_M == 2'b00; i++) begin
            @(posedge clk); #1;
        end
        chk("mem_wait_en", enable_M, 2'b10);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("abort_en", enable_M, 0);
        chk("abort_ready", Ready, 1);
        chk("abort_addr", addr_M, 0);
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_flag = 0;

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 16; i++) begin
                logic [3:0] op;
                op = 4'($urandom_range(0, 15));
                if (op == 4'h5 && i == 15) op = 4'h6;
                prog[i] = {op, 12'($urandom)};
                if (op == 4'h5) prog[i][3:0] = 4'($urandom_range(i + 1, 15));
            end
            load_prog(1'($urandom), 8'($urandom));
            run_prog(-1);
            for (int i = 0; i < 16; i++) prog[i] = 16'h8000 | 16'(i);
            load_prog(0, 8'h00);
            run_prog(-1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
